bist_ctrl: RTL and testbench

BIST_CTRL -- requirements
Module: bist_ctrl

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_lfsr.sv | 23 ++
 rtl/bist_ctrl.sv | 118 +++++++++++
 tb/tb_bist_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state codes, LFSR/signature widths, LFSR taps and default seed.
package bist_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned SIG_W  = 12;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hFF;
    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'b1011_1000;

    typedef logic [2:0] bist_state_t;

    localparam bist_state_t StIdle = 3'd0;
    localparam bist_state_t StInit = 3'd1;
    localparam bist_state_t StRun  = 3'd2;
    localparam bist_state_t StHold = 3'd3;
    localparam bist_state_t StCmp  = 3'd4;
    localparam bist_state_t StDone = 3'd5;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci LFSR pattern generator with synchronous load of the seed.
module bist_lfsr
    import bist_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              enable,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (enable) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// BIST controller: sequences LFSR patterns into the CUT, then compares the MISR signature.
// Optional signature capture output sig_q enabled by defining BIST_SIG_CAPTURE_EN.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned       N_PAT  = 255,
    parameter logic [SIG_W-1:0]  GOLDEN = 12'h000,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [SIG_W-1:0]  hf,
    output logic [LFSR_W-1:0] pattern,
    output logic              misr_rst,
    output logic              bist_end,
    output logic              bist_done,
    output logic              bist_pass
`ifdef BIST_SIG_CAPTURE_EN
    ,
    output logic [SIG_W-1:0]  sig_q
`endif
);

    if (N_PAT < 1 || N_PAT > 65535) begin : g_bad_npat
        $error("bist_ctrl: N_PAT must be in 1..65535");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("bist_ctrl: SEED must be non-zero");
    end

    localparam logic [15:0] LAST_IDX = 16'(N_PAT - 1);

    bist_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lfsr_load, lfsr_en;
    logic        done_d, pass_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StInit;
            StInit:  state_d = StRun;
            StRun:   if (cnt_q == LAST_IDX) state_d = StHold;
            StHold:  state_d = StCmp;
            StCmp:   state_d = StDone;
            StDone:  if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counter indexes the pattern currently presented in RUN; zero on the first RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StRun) begin
            cnt_d = cnt_q + 16'd1;
        end else if (state_q == StIdle || state_q == StInit) begin
            cnt_d = '0;
        end
    end

    // Pattern shows SEED while idle/initialising and freezes once the run leaves RUN.
    assign lfsr_load = (state_d == StIdle) || (state_d == StInit);
    assign lfsr_en   = (state_q == StRun) && (state_d == StRun);

    always_comb begin
        done_d = bist_done;
        pass_d = bist_pass;
        if (state_q == StCmp) begin
            done_d = 1'b1;
            pass_d = (hf == GOLDEN);
        end else if (state_d == StInit) begin
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (state_d == StIdle) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            misr_rst  <= 1'b1;
            bist_end  <= 1'b1;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            misr_rst  <= (state_d == StInit);
            bist_end  <= (state_d != StRun);
            bist_done <= done_d;
            bist_pass <= pass_d;
        end
    end

`ifdef BIST_SIG_CAPTURE_EN
    // Captured signature survives later runs until the next compare overwrites it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sig_q <= '0;
        end else if (state_q == StCmp) begin
            sig_q <= hf;
        end
    end
`endif

    bist_lfsr u_lfsr (
        .CLK    (CLK),
        .RST    (RST),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (SEED),
        .q      (pattern)
    );

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: three instances (N_PAT = 4, 1, 255) against a phase-based model.
module tb_bist_ctrl;

    localparam int unsigned NP0 = 4;
    localparam int unsigned NP1 = 1;
    localparam int unsigned NP2 = 255;
    localparam logic [7:0]  SD0 = 8'hFF;
    localparam logic [7:0]  SD1 = 8'h01;
    localparam logic [7:0]  SD2 = 8'hFF;
    localparam logic [11:0] GOLD = 12'hA5C;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  start;
    logic [11:0] hf;
    logic [7:0]  pat [3];
    logic [2:0]  mr, be, bd, bp;
`ifdef BIST_SIG_CAPTURE_EN
    logic [11:0] sig [3];
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    bist_ctrl #(.N_PAT(NP0), .GOLDEN(GOLD), .SEED(SD0)) u_dut0 (
        .CLK(CLK), .RST(RST), .start(start[0]), .hf(hf), .pattern(pat[0]),
        .misr_rst(mr[0]), .bist_end(be[0]), .bist_done(bd[0]), .bist_pass(bp[0])
`ifdef BIST_SIG_CAPTURE_EN
        , .sig_q(sig[0])
`endif
    );

    bist_ctrl #(.N_PAT(NP1), .GOLDEN(GOLD), .SEED(SD1)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start[1]), .hf(hf), .pattern(pat[1]),
        .misr_rst(mr[1]), .bist_end(be[1]), .bist_done(bd[1]), .bist_pass(bp[1])
`ifdef BIST_SIG_CAPTURE_EN
        , .sig_q(sig[1])
`endif
    );

    bist_ctrl #(.N_PAT(NP2), .GOLDEN(GOLD), .SEED(SD2)) u_dut2 (
        .CLK(CLK), .RST(RST), .start(start[2]), .hf(hf), .pattern(pat[2]),
        .misr_rst(mr[2]), .bist_end(be[2]), .bist_done(bd[2]), .bist_pass(bp[2])
`ifdef BIST_SIG_CAPTURE_EN
        , .sig_q(sig[2])
`endif
    );

    function automatic int n_of(input int k);
        case (k)
            0:       return int'(NP0);
            1:       return int'(NP1);
            default: return int'(NP2);
        endcase
    endfunction

    function automatic logic [7:0] seed_of(input int k);
        case (k)
            0:       return SD0;
            1:       return SD1;
            default: return SD2;
        endcase
    endfunction

    function automatic logic [7:0] lstep(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_state(input int k, input string tag);
        chk($sformatf("%s_misr_rst%0d", tag, k), 32'(mr[k]), 32'd1);
        chk($sformatf("%s_bist_end%0d", tag, k), 32'(be[k]), 32'd1);
        chk($sformatf("%s_pattern%0d", tag, k), 32'(pat[k]), 32'(seed_of(k)));
        chk($sformatf("%s_done%0d", tag, k), 32'(bd[k]), 32'd0);
        chk($sformatf("%s_pass%0d", tag, k), 32'(bp[k]), 32'd0);
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk($sformatf("%s_misr_rst%0d", tag, k), 32'(mr[k]), 32'd0);
        chk($sformatf("%s_bist_end%0d", tag, k), 32'(be[k]), 32'd1);
        chk($sformatf("%s_pattern%0d", tag, k), 32'(pat[k]), 32'(seed_of(k)));
        chk($sformatf("%s_done%0d", tag, k), 32'(bd[k]), 32'd0);
    endtask

    // One full run on instance k; start is released after 'hold' cycles (ignored until DONE).
    // Phase after edge i: 1 INIT, 2..n+1 RUN, n+2 HOLD, n+3 CMP, n+4 DONE.
    task automatic run(input int k, input logic [11:0] hfv, input int hold);
        int         n = n_of(k);
        logic [7:0] p = seed_of(k);
        logic [7:0] last = '0;
        bit         exp_pass = (hfv == GOLD);
        bit         seen [256];
        foreach (seen[j]) seen[j] = 1'b0;
        start[k] = 1'b1;
        hf = 12'($urandom);
        for (int i = 1; i <= n + 4; i++) begin
            bit in_init = (i == 1);
            bit in_run  = (i >= 2) && (i <= n + 1);
            bit in_done = (i == n + 4);
            step();
            chk($sformatf("run%0d_i%0d_misr_rst", k, i), 32'(mr[k]), 32'(in_init));
            chk($sformatf("run%0d_i%0d_bist_end", k, i), 32'(be[k]), 32'(!in_run));
            chk($sformatf("run%0d_i%0d_done", k, i), 32'(bd[k]), 32'(in_done));
            if (in_init) chk($sformatf("run%0d_init_pattern", k), 32'(pat[k]), 32'(seed_of(k)));
            if (in_run) begin
                chk($sformatf("run%0d_i%0d_pattern", k, i), 32'(pat[k]), 32'(p));
                if (k == 2) begin
                    chk($sformatf("lfsr_nonzero_i%0d", i), 32'(pat[k] != 8'h00), 32'd1);
                    chk($sformatf("lfsr_unique_i%0d", i), 32'(seen[pat[k]]), 32'd0);
                    seen[pat[k]] = 1'b1;
                    last = pat[k];
                end
                p = lstep(p);
            end
            if (in_done) begin
                chk($sformatf("run%0d_pass", k), 32'(bp[k]), 32'(exp_pass));
`ifdef BIST_SIG_CAPTURE_EN
                chk($sformatf("run%0d_sig_q", k), 32'(sig[k]), 32'(hfv));
`endif
            end
            if (i == hold) start[k] = 1'b0;
            hf = (i == n + 3) ? hfv : 12'($urandom);
        end
        if (k == 2) chk("lfsr_period_wrap", 32'(lstep(last)), 32'(seed_of(k)));
        if (start[k]) begin
            int extra = int'($urandom_range(1, 3));
            for (int j = 0; j < extra; j++) begin
                step();
                chk($sformatf("done_hold%0d_done", k), 32'(bd[k]), 32'd1);
                chk($sformatf("done_hold%0d_pass", k), 32'(bp[k]), 32'(exp_pass));
                chk($sformatf("done_hold%0d_misr_rst", k), 32'(mr[k]), 32'd0);
            end
            start[k] = 1'b0;
        end
        step();
        chk_idle(k, "post_done");
    endtask

    initial begin
        RST   = 1'b0;
        start = '0;
        hf    = '0;
        repeat (3) step();
        for (int k = 0; k < 3; k++) chk_reset_state(k, "reset");

        RST = 1'b1;
        step();
        for (int k = 0; k < 3; k++) chk_idle(k, "release");
        step();
        chk_idle(0, "idle_stay");

        run(0, GOLD, 1);
        run(0, 12'hA5D, int'($urandom_range(1, 10)));
        run(0, GOLD, 12);
        for (int r = 0; r < 6; r++) begin
            logic [11:0] h = 12'($urandom);
            if ($urandom_range(0, 1) == 1) h = GOLD;
            run(0, h, int'($urandom_range(1, 10)));
        end
        run(1, GOLD, int'($urandom_range(1, 7)));
        run(1, 12'($urandom), int'($urandom_range(1, 7)));
        run(2, GOLD, int'($urandom_range(1, 20)));

        // Reset mid-run: RUN cycle 2 first, then random RUN cycles.
        for (int r = 0; r < 3; r++) begin
            int rc = (r == 0) ? 2 : int'($urandom_range(1, NP0));
            start[0] = 1'b1;
            step();
            start[0] = 1'b0;
            for (int c = 0; c < rc; c++) step();
            chk($sformatf("midrst%0d_bist_end", r), 32'(be[0]), 32'd0);
            RST = 1'b0;
            step();
            chk_reset_state(0, $sformatf("midrst%0d", r));
            RST = 1'b1;
            step();
            chk_idle(0, $sformatf("midrst%0d_rel", r));
            step();
            chk_idle(0, $sformatf("midrst%0d_idle", r));
        end

        // Start already high when reset releases is taken on that edge.
        RST = 1'b0;
        start[0] = 1'b1;
        step();
        chk_reset_state(0, "rst_start");
        RST = 1'b1;
        run(0, GOLD, int'($urandom_range(1, 10)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
